// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - SYSTEM-instruction sequencer: CSR read/modify/write, ecall/ebreak trap entry, mret.
// Optional macro TRAP_CTRL_ILLEGAL_EN turns undecodable instructions and unknown CSRs into ecode-2 traps.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_inst,
  input  logic [63:0] req_pc,
  input  logic [63:0] req_rs1,
  output logic        csr_re,
  output logic [11:0] csr_num,
  input  logic [63:0] csr_rvalue,
  output logic        csr_we,
  output logic [63:0] csr_wmask,
  output logic [63:0] csr_wvalue,
  output logic        ex,
  output logic        ex_ret,
  output logic [63:0] epc,
  output logic [62:0] ecode,
  input  logic [63:0] ex_entry,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        rd_we,
  output logic [4:0]  rd_idx,
  output logic [63:0] rd_wdata,
  output logic        redir_valid,
  output logic [63:0] redir_pc
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, VEC, RET, DONE} state_t;

`ifdef TRAP_CTRL_ILLEGAL_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = DONE;
`endif

  state_t state, state_d;

  logic [11:0] csr_q;
  logic [4:0]  rs1f_q;
  logic [4:0]  rd_q;
  logic [1:0]  op_q;
  logic [63:0] pc_q;
  logic [63:0] src_q;
  logic [62:0] cause_q;
  logic        rd_we_q;
  logic [63:0] rd_wdata_q;
  logic        redir_valid_q;
  logic [63:0] redir_pc_q;

  logic [2:0] f3;
  logic       is_csr, csr_known, csr_go, is_ecall, is_ebreak, is_mret, accept, write_en;

  assign f3        = req_inst[14:12];
  assign is_csr    = (req_inst[6:0] == 7'b1110011) && (f3 != 3'b000) && (f3 != 3'b100);
  assign csr_known = (req_inst[31:20] == 12'h300) || (req_inst[31:20] == 12'h305) ||
                     (req_inst[31:20] == 12'h341) || (req_inst[31:20] == 12'h342);
  assign csr_go    = is_csr && csr_known;
  assign is_ecall  = (req_inst == 32'h0000_0073);
  assign is_ebreak = (req_inst == 32'h0010_0073);
  assign is_mret   = (req_inst == 32'h3020_0073);
  assign accept    = req_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (csr_go)                    state_d = READ;
          else if (is_ecall || is_ebreak) state_d = TRAP;
          else if (is_mret)              state_d = RET;
          else                           state_d = ILLEGAL_NEXT;
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = DONE;
      TRAP:    state_d = VEC;
      VEC:     state_d = DONE;
      RET:     state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_q         <= '0;
      rs1f_q        <= '0;
      rd_q          <= '0;
      op_q          <= '0;
      pc_q          <= '0;
      src_q         <= '0;
      cause_q       <= '0;
      rd_we_q       <= 1'b0;
      rd_wdata_q    <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      if (accept) begin
        csr_q         <= req_inst[31:20];
        rs1f_q        <= req_inst[19:15];
        rd_q          <= req_inst[11:7];
        op_q          <= f3[1:0];
        pc_q          <= req_pc;
        src_q         <= f3[2] ? {59'd0, req_inst[19:15]} : req_rs1;
        cause_q       <= is_ecall ? 63'd11 : (is_ebreak ? 63'd3 : 63'd2);
        rd_we_q       <= 1'b0;
        redir_valid_q <= 1'b0;
      end
      case (state)
        READ:  rd_wdata_q <= csr_rvalue;
        WRITE: rd_we_q    <= (rd_q != 5'd0);
        // Vector is sampled one cycle after ex so the cause is already in mcause.
        VEC: begin
          redir_pc_q    <= ex_entry;
          redir_valid_q <= 1'b1;
        end
        RET: begin
          redir_pc_q    <= csr_rvalue;
          redir_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Set/clear forms with a zero source field must not touch the CSR.
  assign write_en = (op_q == 2'b01) || (rs1f_q != 5'd0);

  assign req_ready   = (state == IDLE);
  assign csr_re      = (state == READ);
  assign csr_num     = csr_q;
  assign csr_we      = (state == WRITE) && write_en;
  assign csr_wmask   = !csr_we ? 64'd0 : ((op_q == 2'b01) ? '1 : src_q);
  assign csr_wvalue  = !csr_we ? 64'd0 : ((op_q == 2'b01) ? src_q : ((op_q == 2'b10) ? '1 : 64'd0));
  assign ex          = (state == TRAP);
  assign ex_ret      = (state == RET);
  assign epc         = pc_q;
  assign ecode       = cause_q;
  assign resp_valid  = (state == DONE);
  assign rd_we       = (state == DONE) && rd_we_q;
  assign rd_idx      = rd_q;
  assign rd_wdata    = rd_wdata_q;
  assign redir_valid = (state == DONE) && redir_valid_q;
  assign redir_pc    = redir_pc_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid / req_ready  in / out  1 / 1  instruction request handshake.
- req_inst  in  32  SYSTEM-class instruction.
- req_pc  in  64  PC of req_inst.
- req_rs1  in  64  rs1 register value.
- csr_re  out  1  CSR read strobe.
- csr_num  out  12  CSR address.
- csr_rvalue  in  64  CSR read data, combinational.
- csr_we  out  1  CSR write strobe.
- csr_wmask, csr_wvalue  out  64, 64  CSR write mask and value.
- ex  out  1  trap-entry strobe.
- ex_ret  out  1  mret strobe.
- epc  out  64  trap PC.
- ecode  out  63  trap cause code.
- ex_entry  in  64  trap vector, combinational.
- resp_valid / resp_ready  out / in  1 / 1  completion handshake.
- rd_we  out  1  integer writeback enable.
- rd_idx  out  5  destination register.
- rd_wdata  out  64  old CSR value.
- redir_valid  out  1  PC redirect required.
- redir_pc  out  64  redirect target.

Function
REQ-002 SHALL use FSM states IDLE, READ, WRITE, TRAP, VEC, RET, DONE; req_ready=1 only in IDLE.
REQ-003 On req_valid&&req_ready SHALL latch inst, pc, rs1; decode opcode 7'b1110011:
- funct3 001/010/011 -> READ, with src=rs1 (csrrw/csrrs/csrrc).
- funct3 101/110/111 -> READ, with src=zero-extended inst[19:15].
- inst 0x00000073 -> TRAP, ecode 11.
- inst 0x00100073 -> TRAP, ecode 3.
- inst 0x30200073 -> RET.
- Anything else -> REQ-014.
REQ-004 READ: csr_re=1, csr_num=inst[31:20] for one cycle; capture csr_rvalue into rd_wdata register; -> WRITE.
REQ-005 WRITE: csr_num held, csr_re=0. Write and mask rules:
- csr_we=1 always for rw forms.
- csr_we=1 for s/c forms only when inst[19:15]!=0.
- rw: wmask=all-ones, wvalue=src.
- s: wmask=src, wvalue=all-ones.
- c: wmask=src, wvalue=0.
Then -> DONE with rd_we=(inst[11:7]!=0), rd_idx=inst[11:7], redir_valid=0.
REQ-006 TRAP: ex=1, epc=latched pc, ecode=cause for exactly one cycle; -> VEC.
REQ-007 VEC: capture ex_entry into redir_pc (cause now registered in CSR, so vectored mode is valid); -> DONE with redir_valid=1, rd_we=0.
REQ-008 RET: ex_ret=1, csr_re=0 for one cycle; capture csr_rvalue (mepc) into redir_pc; -> DONE with redir_valid=1, rd_we=0.
REQ-009 DONE: resp_valid=1 with rd_*, redir_* stable until resp_valid&&resp_ready; then -> IDLE. No new request is accepted in that same cycle.
REQ-010 Latency: accept at cycle N; resp_valid at N+3 for CSR ops and traps, N+2 for mret.
REQ-011 csr_re, csr_we, ex, ex_ret SHALL be mutually exclusive and each asserted at most once per request.
REQ-012 All strobes and csr_wmask/csr_wvalue SHALL be 0 outside their state; epc/ecode/csr_num MAY hold stale values when strobes are low.
REQ-013 resp_ready low SHALL hold DONE indefinitely; req_valid outside IDLE is ignored.

Reset
REQ-015 rst SHALL force IDLE immediately, asynchronously, at any state, with no pending CSR strobe, trap, or response completing afterward.
REQ-016 Reset output values: req_ready=1 (after rst deasserts); resp_valid, rd_we, redir_valid, csr_re, csr_we, ex, ex_ret=0; all data outputs=0.

Configuration
REQ-014 Macro TRAP_CTRL_ILLEGAL_EN:
- Defined: undecodable instructions, and CSR ops whose csr_num is not 0x300/0x305/0x341/0x342, go to TRAP with ecode 2, epc=pc, and issue no csr_re/csr_we.
- Undefined: those cases go directly to DONE with rd_we=0, redir_valid=0, and no strobes (treated as nop).
REQ-017 No other behaviour SHALL depend on the macro.

Verification
REQ-018 The bench SHALL cover at least these scenarios:
- csrrw x5, mtvec(0x305), rs1=0x8000_0000 with CSR=0x100: csr_re at N+1; csr_we at N+2 with mask=all-ones, value=0x8000_0000; resp at N+3 with rd_idx=5, rd_wdata=0x100.
- csrrs x0, mstatus, rs1 field=0: csr_we never asserted; rd_we=0.
- csrrci x3, mepc, imm=3: wmask=0x3, wvalue=0.
- ecall at pc 0x8000_0010, mtvec=0x8000_1000: ex pulse with epc=0x8000_0010, ecode=11; redir_pc=0x8000_1000 at N+3.
- mret with mepc=0x8000_0014: ex_ret pulse at N+1; resp at N+2 with redir_pc=0x8000_0014.
- resp_ready low for 5 cycles, then rst asserted mid-DONE: outputs hold; rst forces IDLE and resp_valid=0 immediately.
- inst=0x0000_0013 with macro on -> ecode 2 trap.
- inst=0x0000_0013 with macro off -> nop response at N+1.
